// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store front end: funct3 codes,
// FSM state encoding, access sizes and default RAM placement.
package mem_pkg;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_4000;
   localparam int unsigned ADDR_W_DEFAULT    = 14;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_IDLE,
      ST_RMW_WR
   } state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   // Low two funct3 bits carry the access size for both signed and unsigned loads.
   function automatic size_e f3_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side and DRAM-side signals of the load/store front end.
interface mem_access_unit_if;
   logic        req_i;
   logic        store_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] load_data_o;
   logic        stall_o;
   logic        fault_o;
   logic [31:0] dram_addr_o;
   logic        dram_we_o;
   logic [31:0] dram_wdata_o;
   logic [31:0] dram_rdata_i;

   modport slave (
      input  req_i, store_i, funct3_i, addr_i, wdata_i, dram_rdata_i,
      output load_data_o, stall_o, fault_o, dram_addr_o, dram_we_o, dram_wdata_o
   );

   modport master (
      output req_i, store_i, funct3_i, addr_i, wdata_i, dram_rdata_i,
      input  load_data_o, stall_o, fault_o, dram_addr_o, dram_we_o, dram_wdata_o
   );
endinterface

// File: rtl/mem_access_unit_byte_lane_merge.sv
// Byte/halfword lane handling: merges new data into a word for stores, or
// (EXTRACT=1) pulls the addressed lane down to bit 0, zero-extended, for loads.
module byte_lane_merge
   import mem_pkg::*;
#(
   parameter bit EXTRACT = 1'b0
) (
   input  logic [31:0] old_word_i,
   input  logic [31:0] new_data_i,
   input  logic [1:0]  lane_i,
   input  size_e       size_i,
   output logic [31:0] word_o
);

   logic [31:0] byte_sh;
   logic [31:0] half_sh;

   assign byte_sh = old_word_i >> {lane_i, 3'b000};
   assign half_sh = old_word_i >> {lane_i[1], 4'b0000};

   always_comb begin
      word_o = old_word_i;
      if (EXTRACT) begin
         case (size_i)
            SZ_B:    word_o = {24'h0, byte_sh[7:0]};
            SZ_H:    word_o = {16'h0, half_sh[15:0]};
            default: word_o = old_word_i;
         endcase
      end else begin
         case (size_i)
            SZ_B:    word_o[{lane_i, 3'b000} +: 8]     = new_data_i[7:0];
            SZ_H:    word_o[{lane_i[1], 4'b0000} +: 16] = new_data_i[15:0];
            default: word_o = new_data_i;
         endcase
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end for a word-only RAM: lane extraction for loads,
// direct word stores, two-cycle read-modify-write for SB/SH, fault decode.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
   parameter int unsigned ADDR_W    = ADDR_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   mem_access_unit_if.slave bus
);

   localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
   localparam logic [32:0] LIMIT    = BASE_EXT + (33'd1 << (ADDR_W + 2));

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] merged_q, merged_d;

   logic [31:0] word_addr;
   size_e       size;
   logic        illegal_f3, misaligned, out_of_range, bad_access;
   logic        idle_req, access_ok, in_rmw, sub_store, word_store;
   logic [31:0] merged_word, lane_raw, load_ext;

   assign word_addr = {bus.addr_i[31:2], 2'b00};
   assign size      = f3_size(bus.funct3_i);
   assign in_rmw    = (state_q == ST_RMW_WR);

   always_comb begin
      case (bus.funct3_i)
         F3_B, F3_H, F3_W: illegal_f3 = 1'b0;
         F3_BU, F3_HU:     illegal_f3 = bus.store_i;
         default:          illegal_f3 = 1'b1;
      endcase
      misaligned   = ((bus.funct3_i[1:0] == 2'b01) && bus.addr_i[0]) ||
                     ((bus.funct3_i == F3_W) && (bus.addr_i[1:0] != 2'b00));
      out_of_range = ({1'b0, bus.addr_i} < BASE_EXT) || ({1'b0, bus.addr_i} >= LIMIT);
      bad_access   = illegal_f3 || misaligned || out_of_range;
   end

   assign idle_req   = bus.req_i && !in_rmw;
   assign access_ok  = idle_req && !bad_access;
   assign sub_store  = access_ok && bus.store_i && (size != SZ_W);
   assign word_store = access_ok && bus.store_i && (size == SZ_W);

   byte_lane_merge #(.EXTRACT(1'b0)) u_merge (
      .old_word_i (bus.dram_rdata_i),
      .new_data_i (bus.wdata_i),
      .lane_i     (bus.addr_i[1:0]),
      .size_i     (size),
      .word_o     (merged_word)
   );

   byte_lane_merge #(.EXTRACT(1'b1)) u_extract (
      .old_word_i (bus.dram_rdata_i),
      .new_data_i ('0),
      .lane_i     (bus.addr_i[1:0]),
      .size_i     (size),
      .word_o     (lane_raw)
   );

   always_comb begin
      case (bus.funct3_i)
         F3_B:    load_ext = {{24{lane_raw[7]}}, lane_raw[7:0]};
         F3_H:    load_ext = {{16{lane_raw[15]}}, lane_raw[15:0]};
         default: load_ext = lane_raw;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      merged_d = merged_q;
      case (state_q)
         ST_IDLE: begin
            if (sub_store) begin
               state_d  = ST_RMW_WR;
               addr_d   = word_addr;
               merged_d = merged_word;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         merged_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         merged_q <= merged_d;
      end
   end

   // Reset gates the strobes directly so a write pending in RMW_WR is dropped.
   assign bus.stall_o      = !rst_i && sub_store;
   assign bus.dram_we_o    = !rst_i && (in_rmw || word_store);
   assign bus.fault_o      = !rst_i && idle_req && bad_access;
   assign bus.dram_addr_o  = in_rmw ? addr_q : word_addr;
   assign bus.dram_wdata_o = in_rmw ? merged_q : bus.wdata_i;
   assign bus.load_data_o  = (access_ok && !bus.store_i) ? load_ext : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a word RAM model
// (asynchronous read, write on falling clock edge).
module tb_mem_access_unit;
   import mem_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   mem_access_unit_if bus ();

   mem_access_unit #(
      .BASE_ADDR (32'h0000_4000),
      .ADDR_W    (14)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   logic [31:0] mem [0:16383] = '{default: 32'h0};
   logic        pre_en;
   logic [13:0] pre_idx;
   logic [31:0] pre_data;
   logic [31:0] rd_off;
   logic [13:0] rd_idx;

   function automatic logic [13:0] widx(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'h0000_4000;
      return off[15:2];
   endfunction

   assign rd_off = bus.dram_addr_o - 32'h0000_4000;
   assign rd_idx = rd_off[15:2];
   assign bus.dram_rdata_i = mem[rd_idx];

   always @(negedge clk) begin
      if (pre_en) mem[pre_idx] = pre_data;
      else if (bus.dram_we_o) mem[rd_idx] = bus.dram_wdata_o;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic req, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      bus.req_i    = req;
      bus.store_i  = st;
      bus.funct3_i = f3;
      bus.addr_i   = a;
      bus.wdata_i  = wd;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      pre_idx  = widx(a);
      pre_data = d;
      pre_en   = 1'b1;
      @(negedge clk);
      #1;
      pre_en = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b1, F3_W, 32'h0000_4000, 32'h1234_5678);
      step();
      step();
      #1;
      total++;
      if (bus.dram_we_o !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", bus.dram_we_o); end
      total++;
      if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", bus.stall_o); end
      drive(1'b1, 1'b0, F3_W, 32'h0000_3FFC, 32'h0);
      #1;
      total++;
      if (bus.fault_o !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", bus.fault_o); end
      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, F3_W, 32'h0000_4007, 32'h0);
      #1;
      total++;
      if ({bus.dram_we_o, bus.stall_o, bus.fault_o} !== 3'b000) begin
         bad++; $display("FAIL idle_strobes: got %b want 000", {bus.dram_we_o, bus.stall_o, bus.fault_o});
      end
      total++;
      if (bus.dram_addr_o !== 32'h0000_4004) begin bad++; $display("FAIL idle_addr: got %h want 00004004", bus.dram_addr_o); end
      total++;
      if (bus.load_data_o !== 32'h0) begin bad++; $display("FAIL idle_load: got %h want 0", bus.load_data_o); end
      step();
   endtask

   logic [2:0]  ld_f3  [8] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_B, F3_B, F3_H};
   logic [31:0] ld_adr [8] = '{32'h4003, 32'h4003, 32'h4002, 32'h4002, 32'h4000, 32'h4000, 32'h4001, 32'h4000};
   logic [31:0] ld_exp [8] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8844, 32'h0000_8844,
                               32'h8844_2211, 32'h0000_0011, 32'h0000_0022, 32'h0000_2211};

   task automatic test_load();
      preload(32'h0000_4000, 32'h8844_2211);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, ld_f3[i], ld_adr[i], 32'h0);
         #1;
         total++;
         if (bus.load_data_o !== ld_exp[i]) begin
            bad++; $display("FAIL load_%0d: got %h want %h", i, bus.load_data_o, ld_exp[i]);
         end
         total++;
         if ({bus.stall_o, bus.fault_o, bus.dram_we_o} !== 3'b000) begin
            bad++; $display("FAIL load_strobe_%0d: got %b want 000", i, {bus.stall_o, bus.fault_o, bus.dram_we_o});
         end
         total++;
         if (bus.dram_addr_o !== 32'h0000_4000) begin
            bad++; $display("FAIL load_addr_%0d: got %h want 00004000", i, bus.dram_addr_o);
         end
         step();
      end
   endtask

   task automatic test_sw();
      drive(1'b1, 1'b1, F3_W, 32'h0000_4010, 32'hDEAD_BEEF);
      #1;
      total++;
      if ({bus.dram_we_o, bus.stall_o} !== 2'b10) begin
         bad++; $display("FAIL sw_strobe: got %b want 10", {bus.dram_we_o, bus.stall_o});
      end
      total++;
      if (bus.dram_wdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wdata: got %h want deadbeef", bus.dram_wdata_o); end
      step();
      drive(1'b1, 1'b0, F3_W, 32'h0000_4010, 32'h0);
      #1;
      total++;
      if (bus.load_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_readback: got %h want deadbeef", bus.load_data_o); end
      step();
   endtask

   task automatic test_sb();
      preload(32'h0000_4020, 32'h1111_1111);
      drive(1'b1, 1'b1, F3_B, 32'h0000_4021, 32'h0000_00AB);
      #1;
      total++;
      if ({bus.stall_o, bus.dram_we_o} !== 2'b10) begin
         bad++; $display("FAIL sb_c1: got %b want 10", {bus.stall_o, bus.dram_we_o});
      end
      step();
      drive(1'b1, 1'b0, F3_W, 32'h0000_4100, 32'h0);
      #1;
      total++;
      if ({bus.stall_o, bus.dram_we_o, bus.fault_o} !== 3'b010) begin
         bad++; $display("FAIL sb_c2: got %b want 010", {bus.stall_o, bus.dram_we_o, bus.fault_o});
      end
      total++;
      if (bus.dram_addr_o !== 32'h0000_4020) begin bad++; $display("FAIL sb_addr: got %h want 00004020", bus.dram_addr_o); end
      total++;
      if (bus.dram_wdata_o !== 32'h1111_AB11) begin bad++; $display("FAIL sb_wdata: got %h want 1111ab11", bus.dram_wdata_o); end
      step();
      drive(1'b1, 1'b0, F3_W, 32'h0000_4020, 32'h0);
      #1;
      total++;
      if (bus.load_data_o !== 32'h1111_AB11) begin bad++; $display("FAIL sb_readback: got %h want 1111ab11", bus.load_data_o); end
      step();
   endtask

   task automatic test_back_to_back();
      int stalls;
      stalls = 0;
      drive(1'b1, 1'b1, F3_H, 32'h0000_4030, 32'h0000_CAFE);
      #1;
      if (bus.stall_o === 1'b1) stalls++;
      step();
      #1;
      if (bus.stall_o === 1'b1) stalls++;
      total++;
      if (bus.dram_wdata_o !== 32'h0000_CAFE) begin bad++; $display("FAIL b2b_sh_wdata: got %h want 0000cafe", bus.dram_wdata_o); end
      step();
      drive(1'b1, 1'b1, F3_B, 32'h0000_4033, 32'h0000_0055);
      #1;
      if (bus.stall_o === 1'b1) stalls++;
      step();
      #1;
      if (bus.stall_o === 1'b1) stalls++;
      total++;
      if ({bus.dram_we_o, bus.dram_wdata_o} !== {1'b1, 32'h5500_CAFE}) begin
         bad++; $display("FAIL b2b_sb_write: got %b/%h want 1/5500cafe", bus.dram_we_o, bus.dram_wdata_o);
      end
      total++;
      if (stalls != 2) begin bad++; $display("FAIL b2b_stalls: got %0d want 2", stalls); end
      step();
      drive(1'b1, 1'b0, F3_W, 32'h0000_4030, 32'h0);
      #1;
      total++;
      if (bus.load_data_o !== 32'h5500_CAFE) begin bad++; $display("FAIL b2b_readback: got %h want 5500cafe", bus.load_data_o); end
      step();
   endtask

   logic        ft_st  [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [2:0]  ft_f3  [9] = '{F3_W, F3_H, F3_W, 3'b011, F3_BU, F3_W, F3_B, 3'b110, F3_B};
   logic [31:0] ft_adr [9] = '{32'h4002, 32'h4001, 32'h3FFC, 32'h4000, 32'h4000,
                               32'h14000, 32'h14000, 32'h4000, 32'h3FFF};

   task automatic test_fault();
      preload(32'h0000_4000, 32'h8844_2211);
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, ft_st[i], ft_f3[i], ft_adr[i], 32'hFFFF_FFFF);
         #1;
         total++;
         if ({bus.fault_o, bus.dram_we_o, bus.stall_o} !== 3'b100) begin
            bad++; $display("FAIL fault_%0d: got %b want 100", i, {bus.fault_o, bus.dram_we_o, bus.stall_o});
         end
         total++;
         if (bus.load_data_o !== 32'h0) begin bad++; $display("FAIL fault_load_%0d: got %h want 0", i, bus.load_data_o); end
         step();
      end
      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      step();
      total++;
      if (mem[0] !== 32'h8844_2211) begin bad++; $display("FAIL fault_ram0: got %h want 88442211", mem[0]); end
      total++;
      if (mem[16383] !== 32'h0) begin bad++; $display("FAIL fault_ramtop: got %h want 0", mem[16383]); end
      preload(32'h0001_3FFC, 32'h0BAD_F00D);
      drive(1'b1, 1'b0, F3_W, 32'h0001_3FFC, 32'h0);
      #1;
      total++;
      if ({bus.fault_o, bus.load_data_o} !== {1'b0, 32'h0BAD_F00D}) begin
         bad++; $display("FAIL top_word: got %b/%h want 0/0badf00d", bus.fault_o, bus.load_data_o);
      end
      step();
   endtask

   task automatic test_reset_rmw();
      drive(1'b1, 1'b1, F3_B, 32'h0000_4040, 32'h0000_0077);
      #1;
      total++;
      if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL rrmw_stall: got %b want 1", bus.stall_o); end
      step();
      rst = 1'b1;
      #1;
      total++;
      if ({bus.dram_we_o, bus.stall_o, bus.fault_o} !== 3'b000) begin
         bad++; $display("FAIL rrmw_gate: got %b want 000", {bus.dram_we_o, bus.stall_o, bus.fault_o});
      end
      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, F3_W, 32'h0000_4040, 32'h0);
      #1;
      total++;
      if ({bus.dram_we_o, bus.stall_o} !== 2'b00) begin
         bad++; $display("FAIL rrmw_idle: got %b want 00", {bus.dram_we_o, bus.stall_o});
      end
      total++;
      if (mem[widx(32'h0000_4040)] !== 32'h0) begin
         bad++; $display("FAIL rrmw_ram: got %h want 0", mem[widx(32'h0000_4040)]);
      end
      step();
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      pre_en = 1'b0;
      pre_idx = '0;
      pre_data = '0;
      rst = 1'b1;
      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      test_reset();
      test_load();
      test_sw();
      test_sb();
      test_back_to_back();
      test_fault();
      test_reset_rmw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
